// File: rtl/edge_seq_pkg.sv
// rtl/edge_seq_pkg.sv - shared types and helpers for edge_event_sequencer
package edge_seq_pkg;

  localparam int MODE_W = 2;

  // Per-channel wait condition selected for a step
  typedef enum logic [MODE_W-1:0] {
    MODE_POS = 2'b00,
    MODE_NEG = 2'b01,
    MODE_ANY = 2'b10,
    MODE_EVT = 2'b11
  } mode_e;

  // Sequencer control states
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // Channel condition for one mode given this cycle's edge and event flags
  function automatic logic mode_match(input mode_e mode, input logic rise,
                                      input logic fall, input logic ev);
    logic hit;
    case (mode)
      MODE_POS: hit = rise;
      MODE_NEG: hit = fall;
      MODE_ANY: hit = rise | fall;
      default:  hit = ev;
    endcase
    return hit;
  endfunction

  // Index of the lowest set bit; 0 when no bit is set
  function automatic logic [4:0] lowest_set_idx(input logic [31:0] vec);
    logic [4:0] idx;
    idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (vec[i[4:0]]) idx = i[4:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/edge_event_sequencer_edge_detect.sv
// rtl/edge_event_sequencer_edge_detect.sv - per-channel edge detector qualified after reset
module edge_detect
  import edge_seq_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic r_prev;
  logic r_prev_vld;

  // previous-sample register; the valid flag masks the first post-reset sample so a level held through reset is not an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev     <= 1'b0;
      r_prev_vld <= 1'b0;
    end else begin
      r_prev     <= sig_i;
      r_prev_vld <= 1'b1;
    end
  end

  assign rise_o = r_prev_vld &  sig_i & ~r_prev;
  assign fall_o = r_prev_vld & ~sig_i &  r_prev;

endmodule

// File: rtl/edge_event_sequencer.sv
// rtl/edge_event_sequencer.sv - programmable multi-channel edge/event wait sequencer
module edge_event_sequencer
  import edge_seq_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int NSTEP = 4,
  parameter int TSW   = 16
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic [NCH-1:0]                                sig_i,
  input  logic [NCH-1:0]                                ev_i,
  input  logic                                          start_i,
  input  logic                                          abort_i,
  input  logic [NSTEP*NCH-1:0]                          step_mask_i,
  input  logic [NSTEP*NCH*MODE_W-1:0]                   step_mode_i,
  output logic                                          busy_o,
  output logic                                          hit_o,
  output logic [((NSTEP > 1) ? $clog2(NSTEP) : 1)-1:0]  hit_step_o,
  output logic [NCH-1:0]                                hit_vec_o,
  output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0]      hit_ch_o,
  output logic [TSW-1:0]                                hit_time_o,
  output logic                                          done_o,
  output logic [TSW-1:0]                                cyc_o
);

  localparam int SW = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  state_e         r_state;
  logic           r_busy;
  logic           r_hit;
  logic           r_done;
  logic [SW-1:0]  r_step;
  logic [SW-1:0]  r_hit_step;
  logic [NCH-1:0] r_hit_vec;
  logic [CW-1:0]  r_hit_ch;
  logic [TSW-1:0] r_hit_time;
  logic [TSW-1:0] r_cyc;
  logic [NCH-1:0] r_mask [NSTEP];
  mode_e          r_mode [NSTEP][NCH];

  logic [NCH-1:0] w_rise;
  logic [NCH-1:0] w_fall;
  logic [NCH-1:0] w_cond;
  logic [NCH-1:0] w_cur_mask;
  logic [NCH-1:0] w_match;
  mode_e          w_cur_mode [NCH];
  logic [NCH-1:0] w_mask_in [NSTEP];
  mode_e          w_mode_in [NSTEP][NCH];
  logic           w_launch;
  logic           w_last_step;
  logic [4:0]     w_low;

  // Per-channel edge detection and condition for the step being waited on
  for (genvar gc = 0; gc < NCH; gc++) begin : g_ch
    edge_detect u_edge (
      .clk    (clk),
      .rst_n  (rst_n),
      .sig_i  (sig_i[gc]),
      .rise_o (w_rise[gc]),
      .fall_o (w_fall[gc])
    );
    assign w_cur_mode[gc] = r_mode[r_step][gc];
    assign w_cond[gc]     = mode_match(w_cur_mode[gc], w_rise[gc], w_fall[gc], ev_i[gc]);
  end

  // Unpack the flat programme ports into per-step views
  for (genvar gs = 0; gs < NSTEP; gs++) begin : g_step
    assign w_mask_in[gs] = step_mask_i[gs*NCH +: NCH];
    for (genvar gm = 0; gm < NCH; gm++) begin : g_mode
      assign w_mode_in[gs][gm] = mode_e'(step_mode_i[(gs*NCH+gm)*MODE_W +: MODE_W]);
    end
  end

  assign w_launch    = (r_state == ST_IDLE) & start_i;
  assign w_cur_mask  = r_mask[r_step];
  assign w_match     = w_cur_mask & w_cond;
  assign w_last_step = (r_step == SW'(NSTEP - 1));
  assign w_low       = lowest_set_idx(32'(w_match));

  // programme latch; only read while waiting, so it carries no reset
  always_ff @(posedge clk) begin
    if (w_launch) begin
      r_mask <= w_mask_in;
      r_mode <= w_mode_in;
    end
  end

  // free-running timestamp counter, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cyc <= '0;
    end else begin
      r_cyc <= r_cyc + 1'b1;
    end
  end

  // step FSM; abort outranks a coincident match, an empty step mask ends the programme
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_busy     <= 1'b0;
      r_hit      <= 1'b0;
      r_done     <= 1'b0;
      r_step     <= '0;
      r_hit_step <= '0;
      r_hit_vec  <= '0;
      r_hit_ch   <= '0;
      r_hit_time <= '0;
    end else begin
      r_hit  <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_state <= ST_WAIT;
            r_busy  <= 1'b1;
            r_step  <= '0;
          end
        end
        ST_WAIT: begin
          if (abort_i) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (w_cur_mask == '0) begin
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (w_match != '0) begin
            r_hit      <= 1'b1;
            r_hit_step <= r_step;
            r_hit_vec  <= w_match;
            r_hit_ch   <= CW'(w_low);
            r_hit_time <= r_cyc;
            if (w_last_step) begin
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_step <= r_step + 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o     = r_busy;
  assign hit_o      = r_hit;
  assign hit_step_o = r_hit_step;
  assign hit_vec_o  = r_hit_vec;
  assign hit_ch_o   = r_hit_ch;
  assign hit_time_o = r_hit_time;
  assign done_o     = r_done;
  assign cyc_o      = r_cyc;

endmodule

// File: tb/tb_edge_event_sequencer.sv
// tb/tb_edge_event_sequencer.sv - directed and randomized self-checking bench for edge_event_sequencer
module tb_edge_event_sequencer;

  localparam logic [1:0] POS = 2'd0;
  localparam logic [1:0] NEG = 2'd1;
  localparam logic [1:0] ANY = 2'd2;
  localparam logic [1:0] EVT = 2'd3;

  logic        clk;
  logic        rst_n;
  logic [3:0]  sig, ev;
  logic        start, abort;
  logic [15:0] step_mask;
  logic [31:0] step_mode;
  logic        busy, hit, done;
  logic [1:0]  hit_step, hit_ch;
  logic [3:0]  hit_vec;
  logic [15:0] hit_time, cyc_o;

  logic [1:0]  wr_sig, wr_ev;
  logic        wr_start, wr_abort;
  logic [3:0]  wr_mask;
  logic [7:0]  wr_mode;
  logic        wr_busy, wr_hit, wr_done;
  logic [0:0]  wr_hit_step, wr_hit_ch;
  logic [1:0]  wr_hit_vec;
  logic [3:0]  wr_hit_time, wr_cyc;

  int total, bad;

  // reference model state
  logic [15:0] m_cyc;
  logic [3:0]  m_prev;
  bit          m_pv, m_busy, m_hit, m_done;
  int          m_step;
  logic [3:0]  m_mask [4];
  logic [1:0]  m_mode [4][4];
  logic [1:0]  m_hstep, m_hch;
  logic [3:0]  m_hvec;
  logic [15:0] m_htime;

  edge_event_sequencer #(.NCH(4), .NSTEP(4), .TSW(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .sig_i(sig), .ev_i(ev), .start_i(start), .abort_i(abort),
    .step_mask_i(step_mask), .step_mode_i(step_mode), .busy_o(busy), .hit_o(hit),
    .hit_step_o(hit_step), .hit_vec_o(hit_vec), .hit_ch_o(hit_ch), .hit_time_o(hit_time),
    .done_o(done), .cyc_o(cyc_o)
  );

  edge_event_sequencer #(.NCH(2), .NSTEP(2), .TSW(4)) u_wrap (
    .clk(clk), .rst_n(rst_n), .sig_i(wr_sig), .ev_i(wr_ev), .start_i(wr_start), .abort_i(wr_abort),
    .step_mask_i(wr_mask), .step_mode_i(wr_mode), .busy_o(wr_busy), .hit_o(wr_hit),
    .hit_step_o(wr_hit_step), .hit_vec_o(wr_hit_vec), .hit_ch_o(wr_hit_ch), .hit_time_o(wr_hit_time),
    .done_o(wr_done), .cyc_o(wr_cyc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void model_reset();
    m_cyc = '0; m_prev = '0; m_pv = 0; m_busy = 0; m_hit = 0; m_done = 0; m_step = 0;
    m_hstep = '0; m_hch = '0; m_hvec = '0; m_htime = '0;
  endfunction

  // one clock of the sequencer described directly by its rules
  function automatic void model_edge(input logic [3:0] s, input logic [3:0] e, input bit st, input bit ab);
    logic [3:0] act;
    act = '0;
    m_hit = 0;
    m_done = 0;
    if (m_busy) begin
      if (ab) begin
        m_busy = 0;
      end else if (m_mask[m_step] == 4'd0) begin
        m_done = 1;
        m_busy = 0;
      end else begin
        for (int c = 0; c < 4; c++) begin
          bit up, dn;
          up = m_pv && s[c] && !m_prev[c];
          dn = m_pv && !s[c] && m_prev[c];
          case (m_mode[m_step][c])
            POS: act[c] = up;
            NEG: act[c] = dn;
            ANY: act[c] = up || dn;
            default: act[c] = e[c];
          endcase
        end
        act = act & m_mask[m_step];
        if (act != 4'd0) begin
          m_hit = 1;
          m_hstep = 2'(m_step);
          m_hvec = act;
          m_htime = m_cyc;
          for (int c = 3; c >= 0; c--) if (act[c]) m_hch = 2'(c);
          if (m_step == 3) begin
            m_done = 1;
            m_busy = 0;
          end else begin
            m_step++;
          end
        end
      end
    end else if (st) begin
      for (int k = 0; k < 4; k++) begin
        m_mask[k] = step_mask[k*4 +: 4];
        for (int c = 0; c < 4; c++) m_mode[k][c] = step_mode[(k*4+c)*2 +: 2];
      end
      m_step = 0;
      m_busy = 1;
    end
    m_prev = s;
    m_pv = 1;
    m_cyc = m_cyc + 16'd1;
  endfunction

  task automatic cyc(input logic [3:0] s, input logic [3:0] e, input logic st, input logic ab);
    sig = s; ev = e; start = st; abort = ab;
    @(posedge clk);
    model_edge(s, e, st, ab);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] s);
    sig = s; ev = '0; start = 0; abort = 0; wr_ev = '0; wr_start = 0;
    rst_n = 0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  task automatic cfg(input int k, input logic [3:0] m, input logic [1:0] md0, input logic [1:0] md1,
                     input logic [1:0] md2, input logic [1:0] md3);
    step_mask[k*4 +: 4] = m;
    step_mode[k*8 +: 8] = {md3, md2, md1, md0};
  endtask

  task automatic test_reset();
    rst_n = 0;
    @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b want=0", busy); end
    total++; if (hit !== 1'b0) begin bad++; $display("FAIL rst_hit got=%0b want=0", hit); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%0b want=0", done); end
    total++; if ({hit_step, hit_ch, hit_vec} !== 8'd0) begin bad++; $display("FAIL rst_hitdata got=%0h want=0", {hit_step, hit_ch, hit_vec}); end
    total++; if (hit_time !== 16'd0) begin bad++; $display("FAIL rst_time got=%0d want=0", hit_time); end
    total++; if (cyc_o !== 16'd0) begin bad++; $display("FAIL rst_cyc got=%0d want=0", cyc_o); end
    rst_n = 1;
    model_reset();
    repeat (5) cyc(4'd0, 4'd0, 0, 0);
    total++; if (cyc_o !== 16'd5) begin bad++; $display("FAIL cyc_count got=%0d want=5", cyc_o); end
    for (int k = 0; k < 4; k++) cfg(k, 4'b0001, POS, POS, POS, POS);
    cyc(4'd0, 4'd0, 1, 0);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL start_busy got=%0b want=1", busy); end
    cyc(4'd1, 4'd0, 0, 0);
    total++; if (hit !== 1'b1) begin bad++; $display("FAIL pre_rst_hit got=%0b want=1", hit); end
    rst_n = 0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL async_busy got=%0b want=0", busy); end
    total++; if ({hit, cyc_o, hit_time} !== 33'd0) begin bad++; $display("FAIL async_clear got=%0h want=0", {hit, cyc_o, hit_time}); end
    @(posedge clk);
    #1;
    rst_n = 1;
    model_reset();
  endtask

  task automatic test_sequence();
    cfg(0, 4'b0011, POS, EVT, POS, POS);
    cfg(1, 4'b0011, POS, EVT, POS, POS);
    cfg(2, 4'b0011, POS, NEG, POS, POS);
    cfg(3, 4'b0011, POS, NEG, POS, POS);
    do_reset(4'b0010);
    cyc(4'b0010, 4'b0000, 0, 0);
    cyc(4'b0010, 4'b0000, 1, 0);
    total++; if ({busy, hit} !== 2'b10) begin bad++; $display("FAIL seq_start got=%0b want=10", {busy, hit}); end
    cyc(4'b0010, 4'b0010, 0, 0);
    total++; if ({hit, hit_step, hit_ch, hit_vec, done} !== {1'b1, 2'd0, 2'd1, 4'b0010, 1'b0})
      begin bad++; $display("FAIL seq_hit0 got=%0b want=%0b", {hit, hit_step, hit_ch, hit_vec, done}, {1'b1, 2'd0, 2'd1, 4'b0010, 1'b0}); end
    total++; if (hit_time !== 16'd2) begin bad++; $display("FAIL seq_time0 got=%0d want=2", hit_time); end
    cyc(4'b0010, 4'b0000, 0, 0);
    total++; if (hit !== 1'b0) begin bad++; $display("FAIL seq_pulse got=%0b want=0", hit); end
    cyc(4'b0011, 4'b0000, 0, 0);
    total++; if ({hit, hit_step, hit_ch, hit_vec, hit_time} !== {1'b1, 2'd1, 2'd0, 4'b0001, 16'd4})
      begin bad++; $display("FAIL seq_hit1 got=%0h want=%0h", {hit, hit_step, hit_ch, hit_vec, hit_time}, {1'b1, 2'd1, 2'd0, 4'b0001, 16'd4}); end
    cyc(4'b0011, 4'b0000, 0, 0);
    cyc(4'b0001, 4'b0000, 0, 0);
    total++; if ({hit, hit_step, hit_ch, hit_vec, hit_time} !== {1'b1, 2'd2, 2'd1, 4'b0010, 16'd6})
      begin bad++; $display("FAIL seq_hit2 got=%0h want=%0h", {hit, hit_step, hit_ch, hit_vec, hit_time}, {1'b1, 2'd2, 2'd1, 4'b0010, 16'd6}); end
    cyc(4'b0000, 4'b0000, 0, 0);
    total++; if (hit !== 1'b0) begin bad++; $display("FAIL seq_nofall got=%0b want=0", hit); end
    cyc(4'b0001, 4'b0000, 0, 0);
    total++; if ({hit, done, hit_step, hit_ch, hit_time} !== {1'b1, 1'b1, 2'd3, 2'd0, 16'd8})
      begin bad++; $display("FAIL seq_hit3 got=%0h want=%0h", {hit, done, hit_step, hit_ch, hit_time}, {1'b1, 1'b1, 2'd3, 2'd0, 16'd8}); end
    cyc(4'b0001, 4'b0000, 0, 0);
    total++; if ({busy, hit, done} !== 3'b000) begin bad++; $display("FAIL seq_end got=%0b want=000", {busy, hit, done}); end
  endtask

  task automatic test_held_high();
    cfg(0, 4'b0001, POS, POS, POS, POS);
    cfg(1, 4'b0000, POS, POS, POS, POS);
    cfg(2, 4'b0001, POS, POS, POS, POS);
    cfg(3, 4'b0001, POS, POS, POS, POS);
    do_reset(4'b0001);
    cyc(4'b0001, 4'b0000, 1, 0);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL held_busy got=%0b want=1", busy); end
    for (int i = 0; i < 4; i++) begin
      cyc(4'b0001, 4'b0000, 0, 0);
      total++; if (hit !== 1'b0) begin bad++; $display("FAIL held_spurious i=%0d got=%0b want=0", i, hit); end
    end
    cyc(4'b0000, 4'b0000, 0, 0);
    total++; if (hit !== 1'b0) begin bad++; $display("FAIL held_fall got=%0b want=0", hit); end
    cyc(4'b0001, 4'b0000, 0, 0);
    total++; if ({hit, hit_step, hit_ch} !== 5'b1_00_00) begin bad++; $display("FAIL held_rise got=%0b want=10000", {hit, hit_step, hit_ch}); end
    cyc(4'b0001, 4'b0000, 0, 0);
    total++; if ({done, hit, busy} !== 3'b100) begin bad++; $display("FAIL zero_mask_done got=%0b want=100", {done, hit, busy}); end
    total++; if ({hit_step, hit_vec} !== 6'b00_0001) begin bad++; $display("FAIL hit_hold got=%0b want=000001", {hit_step, hit_vec}); end
  endtask

  task automatic test_same_cycle();
    cfg(0, 4'b0011, POS, ANY, POS, POS);
    cfg(1, 4'b0011, ANY, ANY, POS, POS);
    cfg(2, 4'b0000, POS, POS, POS, POS);
    cfg(3, 4'b0000, POS, POS, POS, POS);
    do_reset(4'b0000);
    cyc(4'b0000, 4'b0000, 1, 0);
    cyc(4'b0011, 4'b0000, 0, 0);
    total++; if ({hit, hit_vec, hit_ch, hit_step} !== {1'b1, 4'b0011, 2'd0, 2'd0})
      begin bad++; $display("FAIL both_hit got=%0b want=%0b", {hit, hit_vec, hit_ch, hit_step}, {1'b1, 4'b0011, 2'd0, 2'd0}); end
    cyc(4'b0011, 4'b0000, 0, 0);
    total++; if ({hit, busy} !== 2'b01) begin bad++; $display("FAIL one_step_only got=%0b want=01", {hit, busy}); end
    cyc(4'b0010, 4'b0000, 0, 0);
    total++; if ({hit, hit_step, hit_vec} !== {1'b1, 2'd1, 4'b0001}) begin bad++; $display("FAIL step1_hit got=%0b want=%0b", {hit, hit_step, hit_vec}, {1'b1, 2'd1, 4'b0001}); end
  endtask

  task automatic test_abort();
    for (int k = 0; k < 4; k++) cfg(k, 4'b0001, POS, POS, POS, POS);
    do_reset(4'b0000);
    cyc(4'b0000, 4'b0000, 0, 1);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_idle got=%0b want=0", busy); end
    cyc(4'b0000, 4'b0000, 1, 0);
    cyc(4'b0001, 4'b0000, 0, 1);
    total++; if ({hit, done, busy} !== 3'b000) begin bad++; $display("FAIL abort_wins got=%0b want=000", {hit, done, busy}); end
    cyc(4'b0000, 4'b0000, 1, 0);
    cyc(4'b0001, 4'b0000, 0, 0);
    total++; if ({hit, hit_step, hit_time} !== {1'b1, 2'd0, 16'd4}) begin bad++; $display("FAIL restart_hit got=%0h want=%0h", {hit, hit_step, hit_time}, {1'b1, 2'd0, 16'd4}); end
    cyc(4'b0000, 4'b0000, 1, 0);
    cyc(4'b0001, 4'b0000, 0, 0);
    total++; if ({hit, hit_step} !== 3'b1_01) begin bad++; $display("FAIL start_ignored got=%0b want=101", {hit, hit_step}); end
  endtask

  task automatic test_wrap();
    wr_mask = 4'b0001;
    wr_mode = 8'b0000_0011;
    do_reset(4'b0000);
    for (int n = 0; n < 19; n++) begin
      wr_start = (n == 0);
      wr_ev = (n == 17) ? 2'b01 : 2'b00;
      cyc(4'b0000, 4'b0000, 0, 0);
      if (n == 15) begin
        total++; if (wr_cyc !== 4'd0) begin bad++; $display("FAIL wrap_cyc got=%0d want=0", wr_cyc); end
      end
      if (n < 17) begin
        total++; if (wr_hit !== 1'b0) begin bad++; $display("FAIL wrap_early n=%0d got=%0b want=0", n, wr_hit); end
      end
      if (n == 17) begin
        total++; if ({wr_hit, wr_hit_time, wr_cyc, wr_busy} !== {1'b1, 4'd1, 4'd2, 1'b1})
          begin bad++; $display("FAIL wrap_hit got=%0b want=%0b", {wr_hit, wr_hit_time, wr_cyc, wr_busy}, {1'b1, 4'd1, 4'd2, 1'b1}); end
      end
      if (n == 18) begin
        total++; if ({wr_done, wr_hit, wr_busy} !== 3'b100) begin bad++; $display("FAIL wrap_done got=%0b want=100", {wr_done, wr_hit, wr_busy}); end
      end
    end
    wr_start = 0;
    wr_ev = '0;
  endtask

  task automatic test_random();
    logic [3:0] s, e;
    do_reset(4'b0000);
    s = '0;
    for (int i = 0; i < 3000; i++) begin
      step_mode = $urandom;
      step_mask = 16'($urandom);
      for (int k = 0; k < 4; k++) if ($urandom_range(0, 5) == 0) step_mask[k*4 +: 4] = 4'd0;
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 2) == 0) s[b] = ~s[b];
        e[b] = ($urandom_range(0, 5) == 0);
      end
      cyc(s, e, ($urandom_range(0, 5) == 0), ($urandom_range(0, 29) == 0));
      total++; if (hit !== m_hit) begin bad++; $display("FAIL rnd_hit i=%0d got=%0b want=%0b", i, hit, m_hit); end
      total++; if (done !== m_done) begin bad++; $display("FAIL rnd_done i=%0d got=%0b want=%0b", i, done, m_done); end
      total++; if (busy !== m_busy) begin bad++; $display("FAIL rnd_busy i=%0d got=%0b want=%0b", i, busy, m_busy); end
      total++; if (hit_step !== m_hstep) begin bad++; $display("FAIL rnd_step i=%0d got=%0d want=%0d", i, hit_step, m_hstep); end
      total++; if (hit_vec !== m_hvec) begin bad++; $display("FAIL rnd_vec i=%0d got=%0b want=%0b", i, hit_vec, m_hvec); end
      total++; if (hit_ch !== m_hch) begin bad++; $display("FAIL rnd_ch i=%0d got=%0d want=%0d", i, hit_ch, m_hch); end
      total++; if (hit_time !== m_htime) begin bad++; $display("FAIL rnd_time i=%0d got=%0d want=%0d", i, hit_time, m_htime); end
      total++; if (cyc_o !== m_cyc) begin bad++; $display("FAIL rnd_cyc i=%0d got=%0d want=%0d", i, cyc_o, m_cyc); end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 0; sig = '0; ev = '0; start = 0; abort = 0; step_mask = '0; step_mode = '0;
    wr_sig = '0; wr_ev = '0; wr_start = 0; wr_abort = 0; wr_mask = '0; wr_mode = '0;
    model_reset();
    test_reset();
    test_sequence();
    test_held_high();
    test_same_cycle();
    test_abort();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
